regfile: RTL and testbench

REGFILE -- requirements
Module: regfile

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_rport.sv | 52 +++++
 rtl/regfile.sv | 79 +++++++
 tb/tb_regfile.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file sizing constants and address/data types, also used by
// the decode and writeback stages.
package regfile_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int NRP_DEF  = 2;
    localparam int AW_DEF   = $clog2(NREG_DEF);

    typedef logic [AW_DEF-1:0]   rf_addr_t;
    typedef logic [XLEN_DEF-1:0] rf_data_t;

endpackage

// File: rtl/regfile_rport.sv
// One register-file read port: register mux, x0 override and busy lookup.
// Defining REGFILE_BYPASS_EN forwards a same-cycle writeback to this port.
module regfile_rport
    import regfile_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    parameter int AW   = $clog2(NREG)
) (
    input  logic [AW-1:0]        i_raddr,
    input  logic [NREG*XLEN-1:0] i_regs,
    input  logic [NREG-1:0]      i_busy,
    input  logic                 i_wen,
    input  logic [AW-1:0]        i_waddr,
    input  logic [XLEN-1:0]      i_wdata,
    output logic [XLEN-1:0]      o_rdata,
    output logic                 o_rbusy
);

    logic w_nz;
    assign w_nz = (i_raddr != '0);

`ifdef REGFILE_BYPASS_EN
    logic w_hit;
    assign w_hit = i_wen && (i_waddr == i_raddr) && w_nz;

    // A forwarded value is the producer's result, so the port is no longer waiting on it.
    always_comb begin
        o_rdata = '0;
        o_rbusy = 1'b0;
        if (w_hit) begin
            o_rdata = i_wdata;
        end else if (w_nz) begin
            o_rdata = i_regs[i_raddr*XLEN +: XLEN];
            o_rbusy = i_busy[i_raddr];
        end
    end
`else
    logic w_unused;
    assign w_unused = ^{i_wen, i_waddr, i_wdata};

    always_comb begin
        o_rdata = '0;
        o_rbusy = 1'b0;
        if (w_nz) begin
            o_rdata = i_regs[i_raddr*XLEN +: XLEN];
            o_rbusy = i_busy[i_raddr];
        end
    end
`endif

endmodule

// File: rtl/regfile.sv
// Integer register file with per-register busy scoreboard and NRP read ports.
// REGFILE_BYPASS_EN (in regfile_rport) enables same-cycle write forwarding.
module regfile
    import regfile_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    parameter int NRP  = NRP_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NRP*$clog2(NREG)-1:0] raddr,
    output logic [NRP*XLEN-1:0]         rdata,
    output logic [NRP-1:0]              rbusy,
    input  logic                        wen,
    input  logic [$clog2(NREG)-1:0]     waddr,
    input  logic [XLEN-1:0]             wdata,
    input  logic                        iss_valid,
    input  logic [$clog2(NREG)-1:0]     iss_rd,
    input  logic                        flush
);

    localparam int AW = $clog2(NREG);

    logic [NREG*XLEN-1:0] r_regs;
    logic [NREG-1:0]      r_busy;
    logic [NREG-1:0]      w_busy_nxt;
    logic                 w_wen;

    // Keeps the bypass path from forwarding while reset holds the file at zero.
    assign w_wen = wen && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_regs <= '0;
        end else if (wen && waddr != '0) begin
            r_regs[waddr*XLEN +: XLEN] <= wdata;
        end
    end

    // Clear for the writeback first, then set for the issue, so a new producer stays pending.
    always_comb begin
        w_busy_nxt = r_busy;
        if (wen) begin
            w_busy_nxt[waddr] = 1'b0;
        end
        if (iss_valid && iss_rd != '0) begin
            w_busy_nxt[iss_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
        end else if (flush) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    for (genvar g = 0; g < NRP; g++) begin : g_rport
        regfile_rport #(
            .XLEN (XLEN),
            .NREG (NREG),
            .AW   (AW)
        ) u_rport (
            .i_raddr (raddr[g*AW +: AW]),
            .i_regs  (r_regs),
            .i_busy  (r_busy),
            .i_wen   (w_wen),
            .i_waddr (waddr),
            .i_wdata (wdata),
            .o_rdata (rdata[g*XLEN +: XLEN]),
            .o_rbusy (rbusy[g])
        );
    end

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed scenarios plus randomized traffic
// checked against an array-based reference model.
module tb_regfile;

    logic        clk;
    logic        rst;
    logic [14:0] raddr;
    logic [95:0] rdata;
    logic [2:0]  rbusy;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        flush;

    logic [11:0] raddr16;
    logic [95:0] rdata16;
    logic [2:0]  rbusy16;
    logic        wen16;
    logic [3:0]  waddr16;
    logic [31:0] wdata16;

    int n_checks = 0;
    int n_pass   = 0;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic [31:0] m_regs [32];
    bit          m_busy [32];

    regfile #(.XLEN(32), .NREG(32), .NRP(3)) dut (
        .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
        .wen(wen), .waddr(waddr), .wdata(wdata),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .flush(flush)
    );

    regfile #(.XLEN(32), .NREG(16), .NRP(3)) dut16 (
        .clk(clk), .rst(rst), .raddr(raddr16), .rdata(rdata16), .rbusy(rbusy16),
        .wen(wen16), .waddr(waddr16), .wdata(wdata16),
        .iss_valid(1'b0), .iss_rd(4'd0), .flush(1'b0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rd(input int p);
        return rdata[p*32 +: 32];
    endfunction

    task automatic set_ra(input int p, input logic [4:0] a);
        raddr[p*5 +: 5] = a;
    endtask

    task automatic idle();
        wen = 0; waddr = 0; wdata = 0; iss_valid = 0; iss_rd = 0; flush = 0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 0;
            m_busy[i] = 0;
        end
    endtask

    // Advance one clock edge and apply the architectural rules to the model.
    task automatic step();
        @(posedge clk);
        if (!rst) begin
            if (flush) begin
                for (int i = 0; i < 32; i++) m_busy[i] = 0;
            end else begin
                if (wen) m_busy[waddr] = 0;
                if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1;
            end
            if (wen && waddr != 0) m_regs[waddr] = wdata;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1; idle(); raddr = 0;
        wen16 = 0; waddr16 = 0; wdata16 = 0; raddr16 = 0;
        model_clear();
        set_ra(0, 5'd1);
        #3;
        n_checks++;
        if (rd(0) !== 32'h0 || rbusy[0] !== 1'b0)
            $display("FAIL reset_state: rdata=%h rbusy=%b expected 0/0", rd(0), rbusy[0]);
        else n_pass++;
        wen = 1; waddr = 5'd1; wdata = 32'h1234; iss_valid = 1; iss_rd = 5'd1;
        step();
        n_checks++;
        if (rd(0) !== 32'h0 || rbusy[0] !== 1'b0)
            $display("FAIL reset_ignores_inputs: rdata=%h rbusy=%b expected 0/0", rd(0), rbusy[0]);
        else n_pass++;
        @(negedge clk); rst = 0;
        idle(); wen = 1; waddr = 5'd1; wdata = 32'hCAFE0001;
        step();
        idle();
        n_checks++;
        if (rd(0) !== 32'hCAFE0001)
            $display("FAIL first_write_after_reset: rdata=%h expected cafe0001", rd(0));
        else n_pass++;
    endtask

    task automatic test_async_reset();
        idle(); set_ra(0, 5'd5);
        wen = 1; waddr = 5'd5; wdata = 32'hDEADBEEF; iss_valid = 1; iss_rd = 5'd5;
        step();
        idle();
        n_checks++;
        if (rd(0) !== 32'hDEADBEEF || rbusy[0] !== 1'b1)
            $display("FAIL x5_before_reset: rdata=%h rbusy=%b expected deadbeef/1", rd(0), rbusy[0]);
        else n_pass++;
        #2; rst = 1; #1;
        n_checks++;
        if (rd(0) !== 32'h0 || rbusy[0] !== 1'b0)
            $display("FAIL async_reset: rdata=%h rbusy=%b expected 0/0", rd(0), rbusy[0]);
        else n_pass++;
        model_clear();
        @(negedge clk); rst = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_x0();
        idle(); raddr = 0;
        wen = 1; waddr = 0; wdata = 32'hFFFFFFFF; iss_valid = 1; iss_rd = 0;
        #1;
        n_checks++;
        if (rd(1) !== 32'h0 || rbusy[1] !== 1'b0)
            $display("FAIL x0_same_cycle: rdata=%h rbusy=%b expected 0/0", rd(1), rbusy[1]);
        else n_pass++;
        step();
        idle();
        n_checks++;
        if (rd(0) !== 32'h0 || rd(1) !== 32'h0 || rbusy !== 3'b000)
            $display("FAIL x0_after: rdata0=%h rdata1=%h rbusy=%b expected 0/0/000", rd(0), rd(1), rbusy);
        else n_pass++;
    endtask

    task automatic test_scoreboard();
        idle(); set_ra(0, 5'd7);
        iss_valid = 1; iss_rd = 5'd7;
        step();
        idle();
        n_checks++;
        if (rbusy[0] !== 1'b1)
            $display("FAIL sb_set: rbusy=%b expected 1", rbusy[0]);
        else n_pass++;
        wen = 1; waddr = 5'd7; wdata = 32'h12;
        step();
        idle();
        n_checks++;
        if (rbusy[0] !== 1'b0 || rd(0) !== 32'h12)
            $display("FAIL sb_clear: rbusy=%b rdata=%h expected 0/12", rbusy[0], rd(0));
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        idle(); set_ra(0, 5'd3); set_ra(1, 5'd4);
        iss_valid = 1; iss_rd = 5'd3; wen = 1; waddr = 5'd3; wdata = 32'h55;
        step();
        idle();
        n_checks++;
        if (rd(0) !== 32'h55 || rbusy[0] !== 1'b1)
            $display("FAIL set_wins: rdata=%h rbusy=%b expected 55/1", rd(0), rbusy[0]);
        else n_pass++;
        flush = 1; iss_valid = 1; iss_rd = 5'd4;
        step();
        idle();
        n_checks++;
        if (rbusy[1:0] !== 2'b00 || rd(0) !== 32'h55)
            $display("FAIL flush: rbusy=%b rdata=%h expected 00/55", rbusy[1:0], rd(0));
        else n_pass++;
    endtask

    task automatic test_bypass();
        idle(); set_ra(1, 5'd9);
        wen = 1; waddr = 5'd9; wdata = 32'h1111; iss_valid = 1; iss_rd = 5'd9;
        step();
        idle();
        wen = 1; waddr = 5'd9; wdata = 32'hA5A5;
        #1;
        n_checks++;
        if (BYP) begin
            if (rd(1) !== 32'hA5A5 || rbusy[1] !== 1'b0)
                $display("FAIL bypass_same_cycle: rdata=%h rbusy=%b expected a5a5/0", rd(1), rbusy[1]);
            else n_pass++;
        end else begin
            if (rd(1) !== 32'h1111 || rbusy[1] !== 1'b1)
                $display("FAIL nobypass_same_cycle: rdata=%h rbusy=%b expected 1111/1", rd(1), rbusy[1]);
            else n_pass++;
        end
        step();
        idle();
        n_checks++;
        if (rd(1) !== 32'hA5A5 || rbusy[1] !== 1'b0)
            $display("FAIL bypass_next_cycle: rdata=%h rbusy=%b expected a5a5/0", rd(1), rbusy[1]);
        else n_pass++;
    endtask

    task automatic test_multiport();
        idle();
        wen = 1; waddr = 5'd2; wdata = 32'h77;
        step();
        idle();
        for (int p = 0; p < 3; p++) set_ra(p, 5'd2);
        #1;
        for (int p = 0; p < 3; p++) begin
            n_checks++;
            if (rd(p) !== 32'h77)
                $display("FAIL multiport_p%0d: rdata=%h expected 77", p, rd(p));
            else n_pass++;
        end
        wen16 = 1; waddr16 = 4'd2; wdata16 = 32'h77;
        @(posedge clk); #1;
        wen16 = 1; waddr16 = 4'd15; wdata16 = 32'hF00D;
        @(posedge clk); #1;
        wen16 = 0;
        raddr16 = {4'd2, 4'd2, 4'd2};
        #1;
        for (int p = 0; p < 3; p++) begin
            n_checks++;
            if (rdata16[p*32 +: 32] !== 32'h77)
                $display("FAIL multiport16_p%0d: rdata=%h expected 77", p, rdata16[p*32 +: 32]);
            else n_pass++;
        end
        raddr16 = {4'd0, 4'd15, 4'd2};
        #1;
        n_checks++;
        if (rdata16[63:32] !== 32'hF00D || rdata16[95:64] !== 32'h0 || rbusy16 !== 3'b000)
            $display("FAIL nreg16_top: r15=%h r0=%h rbusy=%b expected f00d/0/000",
                     rdata16[63:32], rdata16[95:64], rbusy16);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] exp_d;
        bit          exp_b;
        logic [4:0]  a;
        for (int c = 0; c < 400; c++) begin
            wen       = ($urandom_range(0, 1) == 1);
            waddr     = 5'($urandom_range(0, 31));
            wdata     = $urandom;
            iss_valid = ($urandom_range(0, 2) != 0);
            iss_rd    = 5'($urandom_range(0, 31));
            flush     = ($urandom_range(0, 15) == 0);
            for (int p = 0; p < 3; p++) begin
                if ($urandom_range(0, 2) == 0) set_ra(p, waddr);
                else set_ra(p, 5'($urandom_range(0, 7)));
            end
            @(negedge clk);
            for (int p = 0; p < 3; p++) begin
                a = raddr[p*5 +: 5];
                if (a == 0) begin
                    exp_d = 0; exp_b = 0;
                end else if (BYP && wen && waddr == a) begin
                    exp_d = wdata; exp_b = 0;
                end else begin
                    exp_d = m_regs[a]; exp_b = m_busy[a];
                end
                n_checks++;
                if (rd(p) !== exp_d || rbusy[p] !== exp_b)
                    $display("FAIL random c%0d p%0d x%0d: rdata=%h rbusy=%b expected %h/%b",
                             c, p, a, rd(p), rbusy[p], exp_d, exp_b);
                else n_pass++;
            end
            step();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_async_reset();
        test_x0();
        test_scoreboard();
        test_simultaneous();
        test_bypass();
        test_multiport();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
